pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter WIDTH, default 96: payload width in bits (three 32-bit fields: pc, pc+4, instruction).
REQ-002 Parameter CNT_W, default 16: stall-counter width in bits.
REQ-003 Port sys_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port sys_rst  input  1  reset; synchronous, active-high.
REQ-005 Port flush  input  1  discard all held entries (branch or jump redirect).
REQ-006 Port in_valid  input  1  upstream offers in_data.
REQ-007 Port in_data  input  WIDTH  upstream payload.
REQ-008 Port in_ready  output  1  stage can accept a payload this cycle.
REQ-009 Port out_valid  output  1  out_data holds a valid payload.
REQ-010 Port out_data  output  WIDTH  payload presented downstream.
REQ-011 Port out_ready  input  1  downstream consumes out_data this cycle.
REQ-012 Port stall_cnt  output  CNT_W  count of backpressured cycles.

Function
REQ-013 Storage SHALL be two registers: main (drives out_data/out_valid) and skid (overflow); one entry each.
REQ-014 State SHALL be EMPTY (none held), BUSY (main only), FULL (main+skid); one-hot or encoded, implementer's choice.
REQ-015 in_ready SHALL be 1 in EMPTY/BUSY and 0 in FULL; it SHALL be a function of registered state only (no combinational path from out_ready).
REQ-016 out_valid SHALL be 1 in BUSY/FULL; out_data SHALL equal the main register (no combinational path from in_data).
REQ-017 accept = in_valid & in_ready; fire = out_valid & out_ready.
REQ-018 EMPTY: accept -> main<=in_data, go BUSY; else stay.
REQ-019 BUSY: accept&fire -> main<=in_data, stay BUSY; accept&!fire -> skid<=in_data, go FULL; !accept&fire -> go EMPTY; neither -> stay.
REQ-020 FULL: fire -> main<=skid, go BUSY; else stay, contents held.
REQ-021 Latency SHALL be 1 cycle (accept in cycle N, out_valid in N+1); sustained throughput 1 payload/cycle with out_ready held high.
REQ-022 Payload order SHALL be preserved; no payload duplicated or dropped except by flush.
REQ-023 flush SHALL override all transitions: next state EMPTY regardless of accept/fire; a payload offered in the flush cycle SHALL be dropped; a fire in the flush cycle counts as consumed.
REQ-024 On flush, data registers MAY keep stale contents; out_valid SHALL be 0 the following cycle.
REQ-025 stall_cnt SHALL increment by 1 each cycle with out_valid=1 and out_ready=0, saturate at 2^CNT_W-1, and be unaffected by flush.
REQ-026 When out_valid=0, out_ready SHALL be ignored.

Reset
REQ-027 sys_rst=1 at a clock edge SHALL force state EMPTY, main/skid data to 0, stall_cnt to 0.
REQ-028 Outputs after reset: in_ready=1, out_valid=0, out_data=0, stall_cnt=0.
REQ-029 sys_rst SHALL take priority over flush, accept and fire; a payload offered during reset SHALL be dropped.
REQ-030 Reset asserted in FULL SHALL discard both entries; first cycle after deassertion behaves as EMPTY.

Verification
REQ-031 Stream: out_ready=1, offer A0..A9 back-to-back -> out_data A0..A9 on consecutive cycles, each 1 cycle after accept; in_ready stays 1.
REQ-032 Backpressure: offer A,B,C with out_ready=0 -> A in main, B in skid, in_ready=0 after B, C not accepted; raise out_ready -> A,B,C emitted in order; stall_cnt equals count of cycles with out_valid=1, out_ready=0.
REQ-033 Flush in FULL with in_valid=1 (payload D) -> next cycle out_valid=0, in_ready=1, D never emitted; subsequent E emitted normally.
REQ-034 Simultaneous accept and fire in BUSY -> main replaced, state BUSY, skid unused, no bubble.
REQ-035 CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays 15; flush leaves it 15; sys_rst returns it to 0.
REQ-036 sys_rst asserted for 1 cycle while FULL -> next cycle out_valid=0, out_data=0, in_ready=1; no held payload ever emitted.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register stage: a main register drives the outputs, a skid register absorbs
// the one payload that arrives while downstream stalls, so in_ready depends only on local state.
module pipe_skid_reg #(
  parameter int WIDTH = 96,
  parameter int CNT_W = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             accept, fire;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // State and storage registers
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

  // Next-state and data steering
  always_comb begin
    accept  = in_valid & in_ready;
    fire    = out_valid & out_ready;
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    stall_d = (out_valid & ~out_ready) ? sat_inc(stall_q) : stall_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_d  = in_data;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (accept && fire) begin
          main_d = in_data;
        end else if (accept) begin
          skid_d  = in_data;
          state_d = ST_FULL;
        end else if (fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (fire) begin
          main_d  = skid_q;
          state_d = ST_BUSY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Redirect discards everything held; stale data stays but is never marked valid.
    if (flush) state_d = ST_EMPTY;
  end

  // Outputs from registered state only
  always_comb begin
    in_ready  = (state_q != ST_FULL);
    out_valid = (state_q != ST_EMPTY);
    out_data  = main_q;
    stall_cnt = stall_q;
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Randomized and directed bench for pipe_skid_reg against a queue-based reference model.
module tb_pipe_skid_reg;
  localparam int W  = 96;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          sys_clk = 1'b0;
  logic          sys_rst, flush, in_valid, out_ready;
  logic [W-1:0]  in_data;
  logic          in_ready, out_valid;
  logic [W-1:0]  out_data;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] mq[$];
  int           mcnt;
  bit           mzero;

  pipe_skid_reg #(.WIDTH(W), .CNT_W(CW)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .stall_cnt(stall_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_data();
    return {$urandom, $urandom, $urandom};
  endfunction

  // Drive one cycle, check outputs mid-cycle, then advance the model across the edge.
  task automatic step(input logic r, input logic f, input logic iv,
                      input logic [W-1:0] d, input logic ordy);
    bit v, acc;
    sys_rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    @(negedge sys_clk);
    v = (mq.size() > 0);
    chk("in_ready", in_ready, mq.size() < 2);
    chk("out_valid", out_valid, v);
    chk("stall_cnt", stall_cnt, mcnt);
    if (v) chk("out_data", out_data, mq[0]);
    else if (mzero) chk("out_data_rst", out_data, '0);
    if (r) begin
      mq.delete();
      mcnt  = 0;
      mzero = 1;
    end else begin
      if (v && !ordy && mcnt < CMAX) mcnt++;
      acc = iv && (mq.size() < 2);
      if (acc) mzero = 0;
      if (f) mq.delete();
      else begin
        if (v && ordy) void'(mq.pop_front());
        if (acc) mq.push_back(d);
      end
    end
    @(posedge sys_clk);
    #1;
  endtask

  logic [W-1:0] d;

  initial begin
    sys_rst = 1; flush = 0; in_valid = 0; in_data = '0; out_ready = 0;
    repeat (2) @(posedge sys_clk);
    #1;
    mq.delete(); mcnt = 0; mzero = 1;

    // Reset state
    step(0, 0, 0, '0, 1);
    // Back-to-back stream
    for (int i = 0; i < 10; i++) step(0, 0, 1, W'(32'hA0 + i), 1);
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);
    // Backpressure fills main then skid; third offer refused
    step(0, 0, 1, W'(32'hAAAA), 0);
    step(0, 0, 1, W'(32'hBBBB), 0);
    step(0, 0, 1, W'(32'hCCCC), 0);
    step(0, 0, 1, W'(32'hCCCC), 0);
    step(0, 0, 1, W'(32'hCCCC), 1);
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);
    // Flush while full with a payload offered
    step(0, 0, 1, W'(32'h1111), 0);
    step(0, 0, 1, W'(32'h2222), 0);
    step(0, 1, 1, W'(32'hDDDD), 0);
    step(0, 0, 1, W'(32'hEEEE), 1);
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);
    // Accept and fire together in BUSY
    step(0, 0, 1, W'(32'h3333), 1);
    step(0, 0, 1, W'(32'h4444), 1);
    step(0, 0, 0, '0, 1);
    // Stall counter saturation, flush, reset
    step(0, 0, 1, W'(32'h5555), 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, '0, 0);
    step(0, 1, 0, '0, 0);
    step(0, 0, 0, '0, 0);
    step(1, 0, 0, '0, 0);
    step(0, 0, 0, '0, 0);
    // Reset while full
    step(0, 0, 1, W'(32'h6666), 0);
    step(0, 0, 1, W'(32'h7777), 0);
    step(1, 0, 1, W'(32'h8888), 1);
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      d = rnd_data();
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 49) == 0),
           $urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
